// File: rtl/ads41_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ads41_sample_packer
//  Purpose  : Packs NSAMP sync-aligned ADC samples into one wide word with a
//             valid strobe, per-slot overrange flags and an overrange counter.
//             Define ADS41_TWOS_COMP_EN to convert offset binary to two's
//             complement before packing.
//  Revision : 1.0 - initial release
// ============================================================================
module ads41_sample_packer #(
    parameter int NBITS     = 12,
    parameter int NSAMP     = 4,
    parameter int OVR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din_en,
    input  logic [NBITS-1:0]       din,
    input  logic                   ovr_in,
    input  logic                   sync_in,
    input  logic                   arm,
    input  logic                   ovr_cnt_clr,
    output logic [NSAMP*NBITS-1:0] dout,
    output logic                   dout_valid,
    output logic                   dout_sync,
    output logic [NSAMP-1:0]       ovr_flags,
    output logic [OVR_CNT_W-1:0]   ovr_count,
    output logic                   aligned
);

    localparam int unsigned             c_slot_w    = $clog2(NSAMP);
    localparam logic [c_slot_w-1:0]     c_last_slot = c_slot_w'(NSAMP - 1);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_wait_sync = 2'd1;
    localparam logic [1:0] c_run       = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_sync_q;
    logic [c_slot_w-1:0]     r_slot;
    logic [c_slot_w-1:0]     w_slot_nxt;
    logic [c_slot_w-1:0]     w_wslot;
    logic                    r_pend_sync;
    logic                    w_pend_nxt;
    logic                    w_write;
    logic                    w_emit;
    logic                    w_accept;
    logic                    w_sync_rise;
    logic [NBITS-1:0]        w_sample;
    logic [NSAMP*NBITS-1:0]  r_data;
    logic [NSAMP*NBITS-1:0]  w_data;
    logic [NSAMP-1:0]        r_flags;
    logic [NSAMP-1:0]        w_flag_data;
    logic [NSAMP*NBITS-1:0]  r_dout;
    logic                    r_dout_valid;
    logic                    r_dout_sync;
    logic [NSAMP-1:0]        r_ovr_flags;
    logic [OVR_CNT_W-1:0]    r_ovr_count;

    assign w_sync_rise = sync_in & ~r_sync_q;

`ifdef ADS41_TWOS_COMP_EN
    assign w_sample = {~din[NBITS-1], din[NBITS-2:0]};
`else
    assign w_sample = din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wslot     = r_slot;
        w_pend_nxt  = r_pend_sync;
        w_write     = 1'b0;
        w_emit      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_idle: begin
                w_slot_nxt = '0;
                if (arm && din_en) w_state_nxt = c_wait_sync;
            end
            c_wait_sync: begin
                if (!din_en) begin
                    w_state_nxt = c_idle;
                    w_slot_nxt  = '0;
                end else begin
                    w_accept = 1'b1;
                    if (arm) begin
                        w_slot_nxt = '0;
                    end else if (w_sync_rise) begin
                        w_state_nxt = c_run;
                        w_write     = 1'b1;
                        w_wslot     = '0;
                        w_slot_nxt  = c_slot_w'(1);
                        w_pend_nxt  = 1'b1;
                    end
                end
            end
            c_run: begin
                if (!din_en) begin
                    w_state_nxt = c_idle;
                    w_slot_nxt  = '0;
                end else begin
                    w_accept = 1'b1;
                    if (arm) begin
                        w_state_nxt = c_wait_sync;
                        w_slot_nxt  = '0;
                    end else begin
                        w_write = 1'b1;
                        if (r_slot == c_last_slot) begin
                            // A sync edge on the closing slot still completes this word.
                            w_emit     = 1'b1;
                            w_slot_nxt = '0;
                            w_pend_nxt = w_sync_rise;
                        end else if (w_sync_rise) begin
                            w_wslot    = '0;
                            w_slot_nxt = c_slot_w'(1);
                            w_pend_nxt = 1'b1;
                        end else begin
                            w_slot_nxt = r_slot + c_slot_w'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_slot_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_data      = r_data;
        w_flag_data = r_flags;
        for (int i = 0; i < NSAMP; i++) begin
            if (w_write && (int'(w_wslot) == i)) begin
                w_data[i*NBITS +: NBITS] = w_sample;
                w_flag_data[i]           = ovr_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q     <= 1'b0;
            r_slot       <= '0;
            r_pend_sync  <= 1'b0;
            r_data       <= '0;
            r_flags      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_sync  <= 1'b0;
            r_ovr_flags  <= '0;
            r_ovr_count  <= '0;
        end else begin
            r_sync_q     <= sync_in;
            r_slot       <= w_slot_nxt;
            r_pend_sync  <= w_pend_nxt;
            r_data       <= w_data;
            r_flags      <= w_flag_data;
            r_dout_valid <= w_emit;
            r_dout_sync  <= w_emit & r_pend_sync;
            if (w_emit) begin
                r_dout      <= w_data;
                r_ovr_flags <= w_flag_data;
            end
            if (ovr_cnt_clr) begin
                r_ovr_count <= '0;
            end else if (w_accept && ovr_in && (r_ovr_count != {OVR_CNT_W{1'b1}})) begin
                r_ovr_count <= r_ovr_count + OVR_CNT_W'(1);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_sync  = r_dout_sync;
    assign ovr_flags  = r_ovr_flags;
    assign ovr_count  = r_ovr_count;
    assign aligned    = (r_state == c_run);

endmodule
`default_nettype wire

// File: doc/ads41_sample_packer.md
Name: ads41_sample_packer

Overview:
Sits directly downstream of the ADS41 capture/PLL stage on its output clock domain. Takes one NBITS-wide sample per clock plus the overrange flag. Aligns sample packing to the user sync edge. Packs NSAMP consecutive samples into one wide word with a valid strobe and keeps a saturating overrange counter for the user register interface.

Parameters:
NBITS, 12, ADC sample width.
NSAMP, 4, samples per packed word; power of two, 2..16.
OVR_CNT_W, 16, overrange counter width.

Ports:
clk  input  1  ADC output clock domain; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
din_en  input  1  upstream data qualifier (PLL locked and enabled).
din  input  NBITS  ADC sample, offset binary.
ovr_in  input  1  overrange flag for din.
sync_in  input  1  user sync level; the rising edge is the event.
arm  input  1  one-cycle pulse that requests alignment to the next sync edge.
ovr_cnt_clr  input  1  one-cycle pulse that clears ovr_count.
dout  output  NSAMP*NBITS  packed word; slot 0 (oldest sample) in LSBs.
dout_valid  output  1  one-cycle strobe; dout is valid.
dout_sync  output  1  high with the first dout_valid after alignment.
ovr_flags  output  NSAMP  per-slot overrange bits for dout.
ovr_count  output  OVR_CNT_W  saturating count of overrange samples.
aligned  output  1  high in RUN state.

Behaviour:
- Reset values: dout=0, dout_valid=0, dout_sync=0, ovr_flags=0, ovr_count=0, aligned=0, slot counter=0, state=IDLE, sync edge register=0.
- Sync edge: sync_rise = sync_in & ~sync_q, where sync_q is sync_in registered once. sync_q updates every cycle in every state.
- States:
  - IDLE: leave on arm=1 and din_en=1, go to WAIT_SYNC.
  - WAIT_SYNC: on sync_rise with din_en=1, go to RUN. The sample on that cycle is written to slot 0 and the slot counter is set to 1.
  - RUN: each din_en=1 cycle writes din to the current slot and increments the slot counter modulo NSAMP.
  - Exit to IDLE: din_en=0 in WAIT_SYNC or RUN. The partial word is discarded, the slot counter resets to 0, and no dout_valid is produced.
- Emission: when slot NSAMP-1 is written on cycle t, dout, ovr_flags and dout_valid=1 appear registered on cycle t+1. dout_valid is high for exactly one cycle. Nominal throughput is one word per NSAMP clocks.
- dout_sync: set together with the first dout_valid after entering RUN, or after a realign. Low otherwise.
- Realign in RUN: a sync_rise discards the partial word. The sync-cycle sample goes to slot 0, the counter is set to 1, and the next emitted word carries dout_sync=1. If the sync_rise lands on the slot NSAMP-1 cycle, the completed word is emitted normally and the next word is flagged.
- arm while in WAIT_SYNC or RUN: go to WAIT_SYNC. Partial data is discarded and aligned=0.
- dout and ovr_flags hold their values between strobes.
- ovr_count: increments for each sample accepted with ovr_in=1 in WAIT_SYNC or RUN. It saturates at all-ones with no wrap. ovr_cnt_clr has priority over a same-cycle increment, and the result is 0.
- Reset asserted mid-word: all state is cleared immediately and asynchronously. After deassertion the block returns to IDLE and needs a new arm.

Optional Feature:
ADS41_TWOS_COMP_EN
- Defined: each sample's MSB is inverted before packing, converting offset binary to two's complement. Latency is unchanged.
- Undefined: samples are packed unmodified.

Test Plan:
- Basic packing: arm, then sync_rise with din ramping 0x100,0x101,... -> dout=0x103_102_101_100 one cycle after 0x103 is accepted, dout_sync=1; the next word is 0x107_106_105_104 with dout_sync=0.
- Realign mid-word: in RUN after 2 samples of a word, pulse sync on sample 0x200 -> partial word dropped; next dout=0x203_202_201_200 with dout_sync=1.
- Enable drop: din_en=0 for 1 cycle mid-word -> no dout_valid, aligned=0; re-arm plus sync resumes from slot 0.
- Overrange saturation (OVR_CNT_W=4): ovr_in=1 for 20 accepted samples -> ovr_count=15. Clear together with ovr_in=1 -> 0. ovr_flags=4'b0100 when only slot 2 overranges.
- Async reset mid-word: assert rst_n=0 between clock edges -> outputs 0 before the next edge; after release, no dout_valid until arm plus sync.
- ADS41_TWOS_COMP_EN defined: din=0x800,0x000,0xFFF,0x7FF -> dout=0xFFF_7FF_800_000.
